// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg                                                                  |
// | Shared state encoding, opcode constants and length decode for the fetch    |
// | sequencer. Optional macro: FETCH_TWO_BYTE_EN.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH0 = 2'd0,
        ST_FETCH1 = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_HLT   = 4'hF;
    localparam logic [3:0] OP_2B_LO = 4'h8;
    localparam logic [3:0] OP_2B_HI = 4'hB;

`ifdef FETCH_TWO_BYTE_EN
    localparam bit c_TWO_BYTE_EN = 1'b1;
`else
    localparam bit c_TWO_BYTE_EN = 1'b0;
`endif

    // With the two-byte feature off, every opcode decodes as one byte.
    function automatic logic is_two_byte(input logic [3:0] opcode);
        return c_TWO_BYTE_EN && (opcode >= OP_2B_LO) && (opcode <= OP_2B_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pc_ctrl                                                              |
// | Selects the single PC control pulse (inc/skip/load) for an accepted        |
// | instruction.                                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              i_handshake,
    input  logic [3:0]        i_opcode,
    input  logic [3:0]        i_imm,
    input  logic              i_zero_flag,
    output logic              o_pc_inc,
    output logic              o_pc_skip,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_data
);

    always_comb begin
        o_pc_inc  = 1'b0;
        o_pc_skip = 1'b0;
        o_pc_load = 1'b0;
        o_pc_data = '0;
        if (i_handshake) begin
            if (i_opcode == OP_JMP) begin
                o_pc_load = 1'b1;
                o_pc_data = ADDR_W'(i_imm);
            end else if (i_opcode == OP_JZ) begin
                if (i_zero_flag) begin
                    o_pc_load = 1'b1;
                    o_pc_data = ADDR_W'(i_imm);
                end else begin
                    o_pc_inc = 1'b1;
                end
            end else if (i_opcode == OP_HLT) begin
                o_pc_inc = 1'b0;
            end else if (is_two_byte(i_opcode)) begin
                o_pc_skip = 1'b1;
            end else begin
                o_pc_inc = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer                                                            |
// | Fetches 1/2-byte instructions at the PC, issues them to execute and        |
// | advances the PC. Optional macro: FETCH_TWO_BYTE_EN.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              pc_skip,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              zero_flag,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        instr_opcode,
    output logic [3:0]        instr_imm,
    output logic [DATA_W-1:0] instr_operand,
    output logic              halted
);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_opcode;
    logic [3:0]        r_imm;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_handshake;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Status outputs are qualified with reset so every output reads 0 while it is held.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        w_fetch_addr = pc_addr;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH0: begin
                mem_req = reset;
                if (mem_rvalid) begin
                    w_next_state = is_two_byte(mem_rdata[7:4]) ? ST_FETCH1 : ST_ISSUE;
                end
            end
`ifdef FETCH_TWO_BYTE_EN
            ST_FETCH1: begin
                mem_req      = reset;
                w_fetch_addr = pc_addr + ADDR_W'(1);
                if (mem_rvalid) begin
                    w_next_state = ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                instr_valid = reset;
                if (instr_ready) begin
                    w_next_state = (r_opcode == OP_HLT) ? ST_HALTED : ST_FETCH0;
                end
            end
            ST_HALTED: begin
                halted = reset;
            end
            default: begin
                w_next_state = ST_FETCH0;
            end
        endcase
    end

    assign mem_addr    = mem_req ? w_fetch_addr : '0;
    assign w_handshake = instr_valid & instr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_opcode <= '0;
            r_imm    <= '0;
        end else if ((r_state == ST_FETCH0) && mem_rvalid) begin
            r_opcode <= mem_rdata[7:4];
            r_imm    <= mem_rdata[3:0];
        end
    end

`ifdef FETCH_TWO_BYTE_EN
    logic [DATA_W-1:0] r_operand;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_operand <= '0;
        end else if ((r_state == ST_FETCH0) && mem_rvalid) begin
            r_operand <= '0;
        end else if ((r_state == ST_FETCH1) && mem_rvalid) begin
            r_operand <= mem_rdata;
        end
    end

    assign instr_operand = r_operand;
`else
    assign instr_operand = '0;
`endif

    assign instr_opcode = r_opcode;
    assign instr_imm    = r_imm;

    fetch_pc_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_pc_ctrl (
        .i_handshake (w_handshake),
        .i_opcode    (r_opcode),
        .i_imm       (r_imm),
        .i_zero_flag (zero_flag),
        .o_pc_inc    (pc_inc),
        .o_pc_skip   (pc_skip),
        .o_pc_load   (pc_load),
        .o_pc_data   (pc_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer                                                         |
// | Directed and randomized bench for fetch_sequencer with a transaction-level |
// | memory/PC model. Honors FETCH_TWO_BYTE_EN. Revision: 1.0                   |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

`ifdef FETCH_TWO_BYTE_EN
    localparam bit TWO_EN = 1'b1;
`else
    localparam bit TWO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pc_addr = 4'h0;
    logic       pc_inc, pc_skip, pc_load;
    logic [3:0] pc_data;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_rvalid = 1'b0;
    logic       zero_flag = 1'b0;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [3:0] instr_opcode, instr_imm;
    logic [7:0] instr_operand;
    logic       halted;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr),
        .pc_inc(pc_inc), .pc_skip(pc_skip), .pc_load(pc_load), .pc_data(pc_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .zero_flag(zero_flag), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_imm(instr_imm), .instr_operand(instr_operand),
        .halted(halted)
    );

    logic [7:0] mem [16];
    logic [3:0] pc;
    bit         last_hlt;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [3:0] v);
        pc      = v;
        pc_addr = v;
    endtask

    // One memory read with w wait cycles; request and address must hold throughout.
    task automatic fetch_byte(input logic [3:0] addr, input int w, input string tag);
        for (int i = 0; i <= w; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, mem_req, 1);
            chk({tag, "_addr"}, mem_addr, addr);
            chk({tag, "_valid"}, instr_valid, 0);
            mem_rvalid  = (i == w);
            mem_rdata   = (i == w) ? mem[addr] : 8'($urandom);
            instr_ready = 1'($urandom);
            zero_flag   = 1'($urandom);
            #1;
            chk({tag, "_pulses"}, {pc_inc, pc_skip, pc_load}, 3'b000);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
    endtask

    // Full instruction: fetch, stall in ISSUE, accept, then apply the PC update.
    // zf_mode: 0/1 forces zero_flag, 2 randomizes it.
    task automatic run_instr(input int w0, input int w1, input int stall, input int zf_mode);
        logic [7:0] b0, b1;
        logic [3:0] op, imm, a1;
        logic [2:0] exp_p;
        logic [3:0] exp_d;
        bit         two;
        b0  = mem[pc];
        op  = b0[7:4];
        imm = b0[3:0];
        two = TWO_EN && (op >= 4'h8) && (op <= 4'hB);
        b1  = 8'h00;
        fetch_byte(pc, w0, "f0");
        if (two) begin
            a1 = pc + 4'd1;
            b1 = mem[a1];
            fetch_byte(a1, w1, "f1");
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            instr_ready = (s == stall);
            zero_flag   = (zf_mode == 2) ? 1'($urandom) : 1'(zf_mode);
            mem_rvalid  = 1'($urandom);
            mem_rdata   = 8'($urandom);
            #1;
            chk("iss_valid", instr_valid, 1);
            chk("iss_op", instr_opcode, op);
            chk("iss_imm", instr_imm, imm);
            chk("iss_operand", instr_operand, b1);
            chk("iss_req", mem_req, 0);
            if (s < stall) begin
                chk("stall_pulses", {pc_inc, pc_skip, pc_load}, 3'b000);
            end else begin
                exp_d = 4'h0;
                if (op == 4'h6 || (op == 4'h7 && zero_flag)) begin
                    exp_p = 3'b001; exp_d = imm;
                end else if (op == 4'hF) begin
                    exp_p = 3'b000;
                end else if (two) begin
                    exp_p = 3'b010;
                end else begin
                    exp_p = 3'b100;
                end
                chk("acc_pulses", {pc_inc, pc_skip, pc_load}, exp_p);
                chk("acc_pc_data", pc_data, exp_d);
            end
            @(posedge clk); #1;
        end
        mem_rvalid  = 1'b0;
        instr_ready = 1'b0;
        last_hlt    = (op == 4'hF);
        case (1'b1)
            (op == 4'h6):              set_pc(imm);
            (op == 4'h7 && zero_flag): set_pc(imm);
            (op == 4'hF):              set_pc(pc);
            two:                       set_pc(pc + 4'd2);
            default:                   set_pc(pc + 4'd1);
        endcase
    endtask

    task automatic halted_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_rvalid  = 1'($urandom);
            mem_rdata   = 8'($urandom);
            instr_ready = 1'($urandom);
            #1;
            chk("hlt_halted", halted, 1);
            chk("hlt_req", mem_req, 0);
            chk("hlt_valid", instr_valid, 0);
            chk("hlt_pulses", {pc_inc, pc_skip, pc_load}, 3'b000);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_rvalid  = 1'($urandom);
            mem_rdata   = 8'($urandom);
            instr_ready = 1'($urandom);
            zero_flag   = 1'($urandom);
            #1;
            chk("rst_ctrl", {mem_req, instr_valid, halted, pc_inc, pc_skip, pc_load}, 6'b0);
            chk("rst_data", {mem_addr, pc_data, instr_opcode, instr_imm, instr_operand}, 24'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset       = 1'b1;
        mem_rvalid  = 1'b0;
        instr_ready = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", instr_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        set_pc(4'h0);
        mem[0] = 8'h12;
        do_reset(3);
        run_instr(0, 0, 0, 2);

        set_pc(4'h3); mem[3] = 8'h85; mem[4] = 8'hA7;
        run_instr(0, 0, 0, 2);

        set_pc(4'hF); mem[15] = 8'h90; mem[0] = 8'h33;
        run_instr(1, 2, 0, 2);

        set_pc(4'h9); mem[9] = 8'h7C;
        run_instr(0, 0, 0, 1);
        mem[pc] = 8'h7C;
        run_instr(0, 0, 0, 0);

        mem[pc] = 8'h34;
        run_instr(0, 0, 5, 2);

        for (int k = 0; k < 40; k++) begin
            mem[pc] = ($urandom_range(0, 9) == 0) ? {4'hF, 4'($urandom)}
                                                  : {4'($urandom_range(0, 14)), 4'($urandom)};
            mem[pc + 4'd1] = 8'($urandom);
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2);
            if (last_hlt) begin
                halted_check(2);
                do_reset(1);
            end
        end

        mem[pc] = 8'hF0;
        run_instr(0, 0, 1, 2);
        halted_check(6);
        do_reset(1);

        set_pc(4'h5); mem[5] = 8'h9A; mem[6] = 8'h11;
        if (TWO_EN) fetch_byte(4'h5, 0, "rm_f0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            chk("rm_req", mem_req, 1);
            chk("rm_addr", mem_addr, TWO_EN ? 4'h6 : 4'h5);
            @(posedge clk); #1;
        end
        do_reset(2);
        run_instr(0, 0, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
